// File: rtl/lag_pl_trunk_alloc_pkg.sv
// Shared LAG trunk allocator types: credit width helper and error codes.
// Least-full link choice is enabled by defining LAG_PL_LEAST_FULL_EN.
package lag_pl_trunk_alloc_pkg;

    localparam logic [1:0] ERR_NONE           = 2'b00;
    localparam logic [1:0] ERR_SEND_NO_CREDIT = 2'b01;
    localparam logic [1:0] ERR_CREDIT_OVF     = 2'b10;

    function automatic int cred_w(input int buf_len);
        return $clog2(buf_len + 1);
    endfunction

endpackage

// File: rtl/lag_pl_trunk_alloc_if.sv
// Request/send/credit bundle between input PLs and the trunk allocator.
// Least-full link choice is enabled by defining LAG_PL_LEAST_FULL_EN.
interface lag_pl_trunk_alloc_if #(
    parameter int NUM_IN  = 5,
    parameter int NUM_PLS = 2,
    parameter int BUF_LEN = 4,
    parameter int CW      = lag_pl_trunk_alloc_pkg::cred_w(BUF_LEN)
);
    logic [NUM_IN-1:0]               req;
    logic [NUM_IN-1:0]               send;
    logic [NUM_IN-1:0]               send_tail;
    logic [NUM_PLS-1:0]              credit_in;
    logic [NUM_IN-1:0]               grant;
    logic [NUM_PLS-1:0]              grant_pl;
    logic [NUM_IN-1:0]               alloc_valid;
    logic [NUM_IN-1:0][NUM_PLS-1:0]  alloc_pl;
    logic [NUM_IN-1:0]               can_send;
    logic [NUM_PLS-1:0]              pl_busy;
    logic [NUM_PLS-1:0][CW-1:0]      credits;
    logic                            err;

    modport master (
        output req, send, send_tail, credit_in,
        input  grant, grant_pl, alloc_valid, alloc_pl,
        input  can_send, pl_busy, credits, err
    );

    modport slave (
        input  req, send, send_tail, credit_in,
        output grant, grant_pl, alloc_valid, alloc_pl,
        output can_send, pl_busy, credits, err
    );
endinterface

// File: rtl/lag_pl_trunk_alloc_rr_arbiter.sv
// Round-robin arbiter; top priority sits one past the last grant.
// Least-full link choice is enabled by defining LAG_PL_LEAST_FULL_EN.
module lag_rr_arbiter #(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] gidx;
    logic          found;

    always_comb begin
        grant = '0;
        gidx  = ptr_q;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            int idx;
            idx = int'(ptr_q) + i;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gidx       = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (advance && found) begin
            ptr_q <= (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
        end
    end
endmodule

// File: rtl/lag_pl_trunk_alloc.sv
// Allocates trunk physical links to input PLs with per-link credit tracking.
// Least-full link choice is enabled by defining LAG_PL_LEAST_FULL_EN.
module lag_pl_trunk_alloc
    import lag_pl_trunk_alloc_pkg::*;
#(
    parameter int NUM_IN          = 5,
    parameter int NUM_PLS         = 2,
    parameter int BUF_LEN         = 4,
    parameter int ONLY_WHEN_EMPTY = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lag_pl_trunk_alloc_if.slave  bus
);
    localparam int            CW   = cred_w(BUF_LEN);
    localparam logic [CW-1:0] FULL = CW'(BUF_LEN);

    logic [NUM_IN-1:0]              alloc_valid_q;
    logic [NUM_IN-1:0][NUM_PLS-1:0] alloc_pl_q;
    logic [NUM_PLS-1:0]             busy_q;
    logic [NUM_PLS-1:0][CW-1:0]     cred_q;
    logic                           err_q;

    logic [NUM_PLS-1:0] nz, free, pick, dec, rel;
    logic [NUM_IN-1:0]  arb_req, gnt, can, vsend;
    logic [1:0]         err_code;
    logic               found;

    always_comb begin
        nz   = '0;
        free = '0;
        for (int p = 0; p < NUM_PLS; p++) begin
            nz[p]   = (cred_q[p] != '0);
            free[p] = !busy_q[p] && nz[p] &&
                      (ONLY_WHEN_EMPTY == 0 || cred_q[p] == FULL);
        end
    end

`ifdef LAG_PL_LEAST_FULL_EN
    logic [CW-1:0] best;

    // Strict '>' keeps ties on the lowest index.
    always_comb begin
        pick  = '0;
        best  = '0;
        found = 1'b0;
        for (int p = 0; p < NUM_PLS; p++) begin
            if (free[p] && (!found || cred_q[p] > best)) begin
                pick    = '0;
                pick[p] = 1'b1;
                best    = cred_q[p];
                found   = 1'b1;
            end
        end
    end
`else
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int p = 0; p < NUM_PLS; p++) begin
            if (free[p] && !found) begin
                pick[p] = 1'b1;
                found   = 1'b1;
            end
        end
    end
`endif

    // Gate with rst_n so no grant escapes while reset is held.
    assign arb_req = (rst_n && found) ? (bus.req & ~alloc_valid_q) : '0;

    lag_rr_arbiter #(.N(NUM_IN)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (arb_req),
        .advance (|gnt),
        .grant   (gnt)
    );

    always_comb begin
        can = '0;
        dec = '0;
        rel = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            can[i] = alloc_valid_q[i] && |(alloc_pl_q[i] & nz);
        end
        vsend = bus.send & can;
        for (int i = 0; i < NUM_IN; i++) begin
            if (vsend[i]) begin
                dec = dec | alloc_pl_q[i];
                if (bus.send_tail[i]) rel = rel | alloc_pl_q[i];
            end
        end
    end

    always_comb begin
        err_code = ERR_NONE;
        if (|(bus.send & ~can)) err_code = err_code | ERR_SEND_NO_CREDIT;
        for (int p = 0; p < NUM_PLS; p++) begin
            if (bus.credit_in[p] && !dec[p] && cred_q[p] == FULL)
                err_code = err_code | ERR_CREDIT_OVF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cred_q        <= {NUM_PLS{FULL}};
            alloc_valid_q <= '0;
            alloc_pl_q    <= '0;
            busy_q        <= '0;
            err_q         <= 1'b0;
        end else begin
            err_q  <= err_q | (err_code != ERR_NONE);
            busy_q <= (busy_q & ~rel) | ((|gnt) ? pick : '0);
            for (int p = 0; p < NUM_PLS; p++) begin
                if (bus.credit_in[p] && !dec[p]) begin
                    if (cred_q[p] != FULL) cred_q[p] <= cred_q[p] + 1'b1;
                end else if (dec[p] && !bus.credit_in[p]) begin
                    cred_q[p] <= cred_q[p] - 1'b1;
                end
            end
            for (int i = 0; i < NUM_IN; i++) begin
                if (gnt[i]) begin
                    alloc_valid_q[i] <= 1'b1;
                    alloc_pl_q[i]    <= pick;
                end else if (vsend[i] && bus.send_tail[i]) begin
                    alloc_valid_q[i] <= 1'b0;
                    alloc_pl_q[i]    <= '0;
                end
            end
        end
    end

    assign bus.grant       = gnt;
    assign bus.grant_pl    = (|gnt) ? pick : '0;
    assign bus.alloc_valid = alloc_valid_q;
    assign bus.alloc_pl    = alloc_pl_q;
    assign bus.can_send    = can;
    assign bus.pl_busy     = busy_q;
    assign bus.credits     = cred_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_lag_pl_trunk_alloc.sv
// Directed bench for lag_pl_trunk_alloc (NUM_IN=5, NUM_PLS=2, BUF_LEN=4).
// Link-choice expectation follows LAG_PL_LEAST_FULL_EN.
module tb_lag_pl_trunk_alloc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    lag_pl_trunk_alloc_if #(.NUM_IN(5), .NUM_PLS(2), .BUF_LEN(4)) bus ();

    lag_pl_trunk_alloc #(
        .NUM_IN(5), .NUM_PLS(2), .BUF_LEN(4), .ONLY_WHEN_EMPTY(0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req = '0;
        bus.send = '0;
        bus.send_tail = '0;
        bus.credit_in = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        bus.req = 5'b11111;
        #1;
        total++; if (bus.grant !== 5'b0) begin bad++; $display("FAIL rst_grant got=%b exp=%b", bus.grant, 5'b0); end
        total++; if (bus.can_send !== 5'b0) begin bad++; $display("FAIL rst_can_send got=%b exp=%b", bus.can_send, 5'b0); end
        tick();
        total++; if (bus.credits !== {3'd4, 3'd4}) begin bad++; $display("FAIL rst_credits got=%b exp=%b", bus.credits, {3'd4, 3'd4}); end
        total++; if (bus.alloc_valid !== 5'b0) begin bad++; $display("FAIL rst_alloc_valid got=%b exp=%b", bus.alloc_valid, 5'b0); end
        total++; if (bus.pl_busy !== 2'b0) begin bad++; $display("FAIL rst_pl_busy got=%b exp=%b", bus.pl_busy, 2'b0); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=%b", bus.err, 1'b0); end
        total++; if (bus.grant !== 5'b0) begin bad++; $display("FAIL rst_grant_clk got=%b exp=%b", bus.grant, 5'b0); end
    endtask

    task automatic test_single_grant();
        do_reset();
        bus.req = 5'b00001;
        #1;
        total++; if (bus.grant !== 5'b00001) begin bad++; $display("FAIL single_grant got=%b exp=%b", bus.grant, 5'b00001); end
        total++; if (bus.grant_pl !== 2'b01) begin bad++; $display("FAIL single_grant_pl got=%b exp=%b", bus.grant_pl, 2'b01); end
        total++; if (bus.can_send !== 5'b0) begin bad++; $display("FAIL single_can_send_early got=%b exp=%b", bus.can_send, 5'b0); end
        tick();
        bus.req = '0;
        total++; if (bus.alloc_valid !== 5'b00001) begin bad++; $display("FAIL single_alloc_valid got=%b exp=%b", bus.alloc_valid, 5'b00001); end
        total++; if (bus.alloc_pl[0] !== 2'b01) begin bad++; $display("FAIL single_alloc_pl got=%b exp=%b", bus.alloc_pl[0], 2'b01); end
        total++; if (bus.pl_busy !== 2'b01) begin bad++; $display("FAIL single_pl_busy got=%b exp=%b", bus.pl_busy, 2'b01); end
        total++; if (bus.can_send !== 5'b00001) begin bad++; $display("FAIL single_can_send got=%b exp=%b", bus.can_send, 5'b00001); end
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.req = 5'b00111;
        #1;
        total++; if ({bus.grant, bus.grant_pl} !== {5'b00001, 2'b01}) begin bad++; $display("FAIL rr_first got=%b exp=%b", {bus.grant, bus.grant_pl}, {5'b00001, 2'b01}); end
        tick();
        total++; if ({bus.grant, bus.grant_pl} !== {5'b00010, 2'b10}) begin bad++; $display("FAIL rr_second got=%b exp=%b", {bus.grant, bus.grant_pl}, {5'b00010, 2'b10}); end
        tick();
        total++; if (bus.grant !== 5'b0) begin bad++; $display("FAIL rr_no_link got=%b exp=%b", bus.grant, 5'b0); end
        bus.send = 5'b00001;
        bus.send_tail = 5'b00001;
        #1;
        total++; if (bus.grant !== 5'b0) begin bad++; $display("FAIL rr_release_cycle got=%b exp=%b", bus.grant, 5'b0); end
        tick();
        bus.send = '0;
        bus.send_tail = '0;
        #1;
        total++; if ({bus.grant, bus.grant_pl} !== {5'b00100, 2'b01}) begin bad++; $display("FAIL rr_third got=%b exp=%b", {bus.grant, bus.grant_pl}, {5'b00100, 2'b01}); end
        tick();
        bus.req = '0;
        total++; if (bus.alloc_valid !== 5'b00110) begin bad++; $display("FAIL rr_alloc_valid got=%b exp=%b", bus.alloc_valid, 5'b00110); end
        total++; if (bus.pl_busy !== 2'b11) begin bad++; $display("FAIL rr_pl_busy got=%b exp=%b", bus.pl_busy, 2'b11); end
    endtask

    task automatic test_credits();
        do_reset();
        bus.req = 5'b00001;
        tick();
        bus.req = '0;
        bus.send = 5'b00001;
        repeat (4) tick();
        bus.send = '0;
        total++; if (bus.credits !== {3'd4, 3'd0}) begin bad++; $display("FAIL cred_drained got=%b exp=%b", bus.credits, {3'd4, 3'd0}); end
        total++; if (bus.can_send !== 5'b0) begin bad++; $display("FAIL cred_can_send_zero got=%b exp=%b", bus.can_send, 5'b0); end
        bus.credit_in = 2'b01;
        tick();
        bus.credit_in = '0;
        total++; if (bus.can_send !== 5'b00001) begin bad++; $display("FAIL cred_can_send_back got=%b exp=%b", bus.can_send, 5'b00001); end
        total++; if (bus.credits !== {3'd4, 3'd1}) begin bad++; $display("FAIL cred_one got=%b exp=%b", bus.credits, {3'd4, 3'd1}); end
        bus.send = 5'b00001;
        bus.credit_in = 2'b01;
        tick();
        bus.send = '0;
        bus.credit_in = '0;
        total++; if (bus.credits !== {3'd4, 3'd1}) begin bad++; $display("FAIL cred_send_and_return got=%b exp=%b", bus.credits, {3'd4, 3'd1}); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL cred_err got=%b exp=%b", bus.err, 1'b0); end
    endtask

    task automatic test_link_choice();
        logic [1:0] exp_pl;
`ifdef LAG_PL_LEAST_FULL_EN
        exp_pl = 2'b10;
`else
        exp_pl = 2'b01;
`endif
        do_reset();
        bus.req = 5'b00011;
        tick();
        tick();
        bus.req = '0;
        bus.send = 5'b00011;
        bus.send_tail = 5'b00010;
        tick();
        bus.send = 5'b00001;
        bus.send_tail = 5'b00000;
        tick();
        bus.send_tail = 5'b00001;
        tick();
        bus.send = '0;
        bus.send_tail = '0;
        total++; if (bus.credits !== {3'd3, 3'd1}) begin bad++; $display("FAIL choice_credits got=%b exp=%b", bus.credits, {3'd3, 3'd1}); end
        total++; if (bus.pl_busy !== 2'b00) begin bad++; $display("FAIL choice_pl_busy got=%b exp=%b", bus.pl_busy, 2'b00); end
        bus.req = 5'b00100;
        #1;
        total++; if (bus.grant !== 5'b00100) begin bad++; $display("FAIL choice_grant got=%b exp=%b", bus.grant, 5'b00100); end
        total++; if (bus.grant_pl !== exp_pl) begin bad++; $display("FAIL choice_grant_pl got=%b exp=%b", bus.grant_pl, exp_pl); end
        tick();
        bus.req = '0;
    endtask

    task automatic test_err();
        do_reset();
        bus.credit_in = 2'b01;
        tick();
        bus.credit_in = '0;
        total++; if (bus.credits !== {3'd4, 3'd4}) begin bad++; $display("FAIL err_ovf_credits got=%b exp=%b", bus.credits, {3'd4, 3'd4}); end
        total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL err_ovf got=%b exp=%b", bus.err, 1'b1); end
        tick();
        tick();
        total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=%b", bus.err, 1'b1); end
        do_reset();
        #1;
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL err_cleared got=%b exp=%b", bus.err, 1'b0); end
        bus.send = 5'b00001;
        bus.send_tail = 5'b00001;
        tick();
        bus.send = '0;
        bus.send_tail = '0;
        total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL err_bad_send got=%b exp=%b", bus.err, 1'b1); end
        total++; if (bus.credits !== {3'd4, 3'd4}) begin bad++; $display("FAIL err_bad_send_credits got=%b exp=%b", bus.credits, {3'd4, 3'd4}); end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        bus.req = 5'b00001;
        tick();
        bus.req = '0;
        bus.send = 5'b00001;
        tick();
        bus.send = '0;
        total++; if (bus.credits !== {3'd4, 3'd3}) begin bad++; $display("FAIL mid_credits_before got=%b exp=%b", bus.credits, {3'd4, 3'd3}); end
        bus.req = 5'b00011;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.alloc_valid !== 5'b0) begin bad++; $display("FAIL mid_alloc_valid got=%b exp=%b", bus.alloc_valid, 5'b0); end
        total++; if (bus.credits !== {3'd4, 3'd4}) begin bad++; $display("FAIL mid_credits got=%b exp=%b", bus.credits, {3'd4, 3'd4}); end
        total++; if (bus.can_send !== 5'b0) begin bad++; $display("FAIL mid_can_send got=%b exp=%b", bus.can_send, 5'b0); end
        total++; if (bus.grant !== 5'b0) begin bad++; $display("FAIL mid_grant got=%b exp=%b", bus.grant, 5'b0); end
        total++; if (bus.pl_busy !== 2'b0) begin bad++; $display("FAIL mid_pl_busy got=%b exp=%b", bus.pl_busy, 2'b0); end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_grant();
        test_round_robin();
        test_credits();
        test_link_choice();
        test_err();
        test_reset_mid_packet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lag_pl_trunk_alloc.md
LAG_PL_TRUNK_ALLOC -- requirements
Module: lag_pl_trunk_alloc

Interface
REQ-001 SHALL have parameter NUM_IN, default 5: number of requesting input PLs.
REQ-002 SHALL have parameter NUM_PLS, default 2: physical links in the output trunk.
REQ-003 SHALL have parameter BUF_LEN, default 4: downstream FIFO depth, which is also the initial credit count per link.
REQ-004 SHALL have parameter ONLY_WHEN_EMPTY, default 0: when 1, a link is allocatable only when it holds full credits.
REQ-005 SHALL have ports: clk input 1, rising-edge clock; rst_n input 1, reset, asynchronous active-low.
REQ-006 SHALL have ports: req input NUM_IN, head flit waiting for this trunk; send input NUM_IN, flit sent on the input's allocated link; send_tail input NUM_IN, qualifies send as the tail flit.
REQ-007 SHALL have port credit_in input NUM_PLS, one-cycle credit return per link.
REQ-008 SHALL have ports: grant output NUM_IN, one-hot pulse; grant_pl output NUM_PLS, one-hot link for the grant.
REQ-009 SHALL have ports: alloc_valid output NUM_IN; alloc_pl output NUM_IN x NUM_PLS, one-hot held allocation.
REQ-010 SHALL have ports: can_send output NUM_IN; pl_busy output NUM_PLS; credits output NUM_PLS x CW, where CW = clog2(BUF_LEN+1); err output 1, sticky.

Function
REQ-011 SHALL treat an input as eligible when req=1 and alloc_valid=0.
REQ-012 SHALL treat a link as free when pl_busy=0 and credits>0, plus credits==BUF_LEN if ONLY_WHEN_EMPTY=1.
REQ-013 SHALL issue at most one grant per cycle, combinationally, when at least one input is eligible and at least one link is free.
REQ-014 SHALL choose the granted input round-robin; priority starts one past the last granted input, wrapping from NUM_IN-1 to 0, and the pointer advances only on a grant.
REQ-015 SHALL load alloc_valid, alloc_pl and pl_busy at the clock edge after a grant, so a new grant has 1-cycle latency to can_send.
REQ-016 SHALL compute can_send[i] = alloc_valid[i] and credits of the allocated link > 0.
REQ-017 SHALL treat send[i] with can_send[i]=1 as valid: decrement that link's credits; if send_tail[i]=1, also clear alloc_valid[i] and pl_busy at the next edge.
REQ-018 SHALL keep a released link non-free in the release cycle, so it is grantable from the following cycle; no same-cycle reuse.
REQ-019 SHALL add 1 to a link's credits on credit_in, regardless of pl_busy; a valid send and credit_in on the same link in one cycle leave credits unchanged.
REQ-020 SHALL treat send[i] with can_send[i]=0 as ignored (no credit change, no release) and set err.
REQ-021 SHALL saturate credit_in at credits==BUF_LEN (no change, unless a simultaneous valid send) and set err.
REQ-022 SHALL keep err set until reset.
REQ-023 SHALL ensure two inputs never hold the same link.

Reset
REQ-024 SHALL, on rst_n low: credits=BUF_LEN on all links; alloc_valid, alloc_pl, pl_busy and err = 0; round-robin pointer set to input 0 as top priority.
REQ-025 SHALL drop an allocation in progress on reset mid-packet, with no credit reconciliation.
REQ-026 SHALL hold grant and can_send at 0 during reset.

Configuration
REQ-027 SHALL, with LAG_PL_LEAST_FULL_EN defined, choose the free link with the most credits (ties to the lowest index); without it, choose the lowest-index free link.

Structure
REQ-028 SHALL place a credit-width function and the error-code constants in the shared lag package.
REQ-029 SHALL implement round-robin selection as sub-module lag_rr_arbiter (parameter N; ports req, advance, grant).

Verification
REQ-030 SHALL cover: after reset, credits=4,4 and req=00001 -> grant=00001, grant_pl=01; alloc_valid[0]=1 next cycle.
REQ-031 SHALL cover: three requesters, two links -> two grants on consecutive cycles; the third is granted only the cycle after a send_tail.
REQ-032 SHALL cover: four sends without credit_in -> credits=0, can_send=0; one credit_in -> can_send=1 next cycle.
REQ-033 SHALL cover: with LAG_PL_LEAST_FULL_EN, credits link0=1 and link1=3, both free -> grant_pl=10; without the macro -> 01.
REQ-034 SHALL cover: credit_in while credits=4 -> credits stay 4, err=1 and stays set; send with can_send=0 -> err=1.
REQ-035 SHALL cover: rst_n pulse mid-packet -> all alloc_valid=0, credits=4 immediately, without waiting for clk.
